// File: rtl/piso_tx_pkg.sv
// ---------------------------------------------------------------------------
// piso_tx_pkg
// Shared definitions for the round-robin PISO transmit scheduler.
//   state_t      : scheduler FSM states (IDLE, SHIFT, GAP)
//   owner_width  : width of an index into NUM_REQ requesters (at least 1)
//   frame_len    : serial bits per frame; WIDTH, plus one parity bit when
//                  PISO_TX_PARITY_EN is defined
//   OWNER_W / FRAME_LEN : values for the default configuration (4 x 4 bits)
// Optional feature macro: PISO_TX_PARITY_EN
// ---------------------------------------------------------------------------
package piso_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int WIDTH_DEF   = 4;

    function automatic int owner_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int frame_len(input int w);
`ifdef PISO_TX_PARITY_EN
        return w + 1;
`else
        return w;
`endif
    endfunction

    localparam int OWNER_W   = owner_width(NUM_REQ_DEF);
    localparam int FRAME_LEN = frame_len(WIDTH_DEF);

endpackage

// File: rtl/piso_rr_arbiter.sv
// ---------------------------------------------------------------------------
// piso_rr_arbiter
// Combinational round-robin search. Starting at rr_ptr and wrapping, the
// first asserted valid bit wins.
//   valid     in  NUM_REQ  request vector
//   rr_ptr    in  OW       highest-priority index for this search
//   grant     out NUM_REQ  one-hot grant (all zero when nothing is valid)
//   grant_idx out OW       index of the granted requester (0 when none)
//   any_valid out 1        at least one request is valid
// ---------------------------------------------------------------------------
module piso_rr_arbiter
    import piso_tx_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int OW      = owner_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [OW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [OW-1:0]      grant_idx,
    output logic               any_valid
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // rr_ptr is always < NUM_REQ, so a single subtraction wraps.
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_valid && valid[idx]) begin
                any_valid      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = OW'(idx);
            end
        end
    end

endmodule

// File: rtl/piso_tx_scheduler.sv
// ---------------------------------------------------------------------------
// piso_tx_scheduler
// Shares one parallel-in/serial-out shifter between NUM_REQ requesters.
// A round-robin arbiter picks one word per frame; the word is shifted out
// MSB-first with first/last strobes, followed by GAP_CYCLES idle cycles.
//
// Handshake: in IDLE the granted requester sees req_ready high in the same
// cycle (combinational from req_valid); the word transfers on the rising
// edge where req_valid[i] and req_ready[i] are both high. req_ready is zero
// in every other state.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid [NUM_REQ]   per-requester word available
//   req_data  [NUM_REQ*WIDTH] packed words, requester i at [i*WIDTH +: WIDTH]
//   req_ready [NUM_REQ]   one-hot grant
//   ser_out/ser_valid     serial bit and its qualifier
//   ser_first/ser_last    frame delimiters
//   owner                 requester index of the current/last frame
//   busy                  high whenever the FSM is not IDLE
// Optional feature macro: PISO_TX_PARITY_EN (appends an even-parity bit)
// ---------------------------------------------------------------------------
module piso_tx_scheduler
    import piso_tx_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        ser_out,
    output logic                        ser_valid,
    output logic                        ser_first,
    output logic                        ser_last,
    output logic [owner_width(NUM_REQ)-1:0] owner,
    output logic                        busy
);

    localparam int OW    = owner_width(NUM_REQ);
    localparam int FL    = frame_len(WIDTH);
    // One counter serves both the bit index in SHIFT and the gap count.
    localparam int CNT_W = $clog2(((FL > GAP_CYCLES) ? FL : GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FL - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [OW-1:0]      rr_ptr;

    logic [NUM_REQ-1:0] grant;
    logic [OW-1:0]      grant_idx;
    logic               any_valid;
    logic [WIDTH-1:0]   sel_word;
    logic [OW-1:0]      ptr_after;

`ifdef PISO_TX_PARITY_EN
    logic               parity_q;
`endif

    piso_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .OW      (OW)
    ) u_arb (
        .valid     (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    assign sel_word  = req_data[int'(grant_idx)*WIDTH +: WIDTH];
    assign ptr_after = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next state and outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        ser_first = 1'b0;
        ser_last  = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                req_ready = grant;
                if (any_valid) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ser_valid = 1'b1;
`ifdef PISO_TX_PARITY_EN
                // Data bits are exhausted once bit_cnt reaches WIDTH.
                ser_out = (bit_cnt == CNT_W'(WIDTH)) ? parity_q : shreg[WIDTH-1];
`else
                ser_out = shreg[WIDTH-1];
`endif
                ser_first = (bit_cnt == '0);
                ser_last  = (bit_cnt == LAST_BIT);
                if (bit_cnt == LAST_BIT) begin
                    state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (bit_cnt == GAP_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: capture, shift, counters, round-robin pointer, owner
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            rr_ptr  <= '0;
            owner   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        shreg   <= sel_word;
                        owner   <= grant_idx;
                        rr_ptr  <= ptr_after;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    shreg   <= shreg << 1;
                    bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                end
                ST_GAP: begin
                    bit_cnt <= (bit_cnt == GAP_LAST) ? '0 : bit_cnt + 1'b1;
                end
                default: begin
                    bit_cnt <= '0;
                end
            endcase
        end
    end

`ifdef PISO_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (state == ST_IDLE && any_valid) begin
            parity_q <= ^sel_word;
        end
    end
`endif

endmodule
